// File: rtl/exchange_port_arbiter_if.sv
// Exchange-port arbiter bus: core request/grant handshake plus the port-1 memory
// signals. The arbiter uses the master modport; requesters and memory use slave.
interface exchange_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int A_W  = 5,
  parameter int D_W  = 1
);
  logic [NREQ-1:0]     REQ;
  logic [NREQ-1:0]     WE_REQ;
  logic [NREQ*A_W-1:0] ADDR_REQ;
  logic [NREQ*D_W-1:0] DI_REQ;
  logic [NREQ-1:0]     GNT;
  logic [NREQ-1:0]     ACK;
  logic [D_W-1:0]      DQ_REQ;
  logic                BUSY;
  logic [A_W-1:0]      A_1;
  logic [D_W-1:0]      DI_1;
  logic                WE_1;
  logic [D_W-1:0]      DQ_1;

  modport master (
    input  REQ, WE_REQ, ADDR_REQ, DI_REQ, DQ_1,
    output GNT, ACK, DQ_REQ, BUSY, A_1, DI_1, WE_1
  );

  modport slave (
    output REQ, WE_REQ, ADDR_REQ, DI_REQ, DQ_1,
    input  GNT, ACK, DQ_REQ, BUSY, A_1, DI_1, WE_1
  );
endinterface

// File: rtl/exchange_port_arbiter.sv
// Round-robin arbiter/sequencer sharing image_memory port 1 between NREQ cores.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest REQ index wins, no pointer).
module exchange_port_arbiter #(
  parameter int NREQ = 4,
  parameter int A_W  = 5,
  parameter int D_W  = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  exchange_port_arbiter_if.master bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, RD, WR_SET, WR_CMT, DONE} state_t;

  state_t           state, state_nx;
  logic             any_req;
  logic [IDX_W-1:0] win;
  logic [A_W-1:0]   addr_sel, addr_q;
  logic [D_W-1:0]   di_sel, di_q, dq_q;
  logic             we_sel;
  logic [NREQ-1:0]  gnt_q;
  logic             drive;
  logic             start;

  assign any_req = |bus.REQ;
  assign start   = (state == IDLE) && any_req;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.REQ[k]) win = IDX_W'(k);
    end
  end
`else
  logic [IDX_W-1:0] ptr, idx_q, cand;
  logic [IDX_W:0]   sum;
  logic             found;

  // Search upward from ptr+1, wrapping at NREQ; first set REQ wins.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      cand = sum[IDX_W-1:0];
      if (!found && bus.REQ[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr   <= IDX_W'(NREQ - 1);
      idx_q <= '0;
    end else begin
      if (start)         idx_q <= win;
      if (state == DONE) ptr   <= idx_q;
    end
  end
`endif

  always_comb begin
    addr_sel = '0;
    di_sel   = '0;
    we_sel   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IDX_W'(k)) begin
        addr_sel = bus.ADDR_REQ[k*A_W +: A_W];
        di_sel   = bus.DI_REQ[k*D_W +: D_W];
        we_sel   = bus.WE_REQ[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = we_sel ? WR_SET : RD;
      RD:      state_nx = DONE;
      WR_SET:  state_nx = WR_CMT;
      WR_CMT:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q <= '0;
      dq_q  <= '0;
    end else begin
      if (start)         gnt_q <= NREQ'(1) << win;
      if (state == DONE) gnt_q <= '0;
      if (state == RD)   dq_q  <= bus.DQ_1;
    end
  end

  // Address/data are only observed while granted, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (start) begin
      addr_q <= addr_sel;
      di_q   <= di_sel;
    end
  end

  // Port-1 signals are decoded from state so an async reset clears them at once.
  assign drive      = (state == RD) || (state == WR_SET) || (state == WR_CMT);
  assign bus.A_1    = drive ? addr_q : '0;
  assign bus.DI_1   = ((state == WR_SET) || (state == WR_CMT)) ? di_q : '0;
  assign bus.WE_1   = (state == WR_SET);
  assign bus.GNT    = gnt_q;
  assign bus.ACK    = (state == DONE) ? gnt_q : '0;
  assign bus.DQ_REQ = dq_q;
  assign bus.BUSY   = (state != IDLE);

endmodule
